hs_sync_aligner: RTL and testbench

Receive-side HS word aligner for the MIPI D-PHY data lane. It sits directly downstream of the 8-bit deserializer, in the RxByteClkHS domain. It hunts for the HS sync sequence at any of the 8 bit offsets in the raw deserialized byte stream, locks that offset, and delivers bit-order-corrected, byte-aligned payload to the PPI. The PPI signals are RxDataHS, RxValidHS, RxActiveHS and RxSyncHS, and the aligner also reports start-of-transmission errors.

---
 rtl/hs_sync_aligner.sv | 217 +++++++++++++++++++++
 tb/tb_hs_sync_aligner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hs_sync_aligner.sv
// D-PHY HS receive word aligner: hunts the sync byte at any of 8 bit offsets,
// locks the offset and delivers LSB-first-corrected payload bytes to the PPI.
module hs_sync_aligner #(
    parameter logic [7:0] SYNC_PATTERN   = 8'hB8,
    parameter int         SYNC_TIMEOUT   = 16,
    parameter bit         ALLOW_1BIT_ERR = 1'b1
) (
    input  logic       RxByteClkHS,
    input  logic       RxRst,
    input  logic [7:0] parallel_in,
    input  logic       deserializer_en,
    output logic [7:0] RxDataHS,
    output logic       RxValidHS,
    output logic       RxActiveHS,
    output logic       RxSyncHS,
    output logic       ErrSotHS,
    output logic       ErrSotSyncHS
);

    localparam logic [7:0] TIMEOUT_LIMIT = SYNC_TIMEOUT[7:0];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HUNT   = 2'd1,
        ACTIVE = 2'd2,
        ERROR  = 2'd3
    } state_t;

    state_t          state;
    state_t          next_state;

    logic [7:0]      prev;
    logic [15:0]     window;
    logic [7:0][7:0] cand;
    logic [7:0]      exact;
    logic [7:0]      near;

    logic            found_exact;
    logic            found_near;
    logic [2:0]      exact_idx;
    logic [2:0]      near_idx;
    logic            match;
    logic            match_err;
    logic [2:0]      match_idx;

    logic [2:0]      offset;
    logic [7:0]      timeout_cnt;
    logic [7:0]      cnt_inc;
    logic            timeout_hit;

    logic [7:0]      data_d;
    logic            valid_d;
    logic            active_d;
    logic            sync_d;
    logic            err_sot_d;
    logic            err_sync_d;

    function automatic logic [7:0] bit_reverse(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Older byte sits at the high end, so candidate k starts k bits into prev.
    assign window = {prev, parallel_in};

    for (genvar g = 0; g < 8; g++) begin : g_cand
        logic [7:0] diff;
        assign cand[g]  = window[15-g -: 8];
        assign diff     = cand[g] ^ SYNC_PATTERN;
        assign exact[g] = (diff == 8'd0);
        assign near[g]  = (diff != 8'd0) && ((diff & (diff - 8'd1)) == 8'd0);
    end

    // Scan from high to low offset so the lowest matching k is the one kept.
    always_comb begin
        found_exact = 1'b0;
        found_near  = 1'b0;
        exact_idx   = 3'd0;
        near_idx    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (exact[k]) begin
                found_exact = 1'b1;
                exact_idx   = 3'(k);
            end
            if (near[k]) begin
                found_near = 1'b1;
                near_idx   = 3'(k);
            end
        end
    end

    assign match     = found_exact || (ALLOW_1BIT_ERR && found_near);
    assign match_err = !found_exact;
    assign match_idx = found_exact ? exact_idx : near_idx;

    assign cnt_inc     = timeout_cnt + 8'd1;
    assign timeout_hit = (cnt_inc == TIMEOUT_LIMIT);

    always_ff @(posedge RxByteClkHS or posedge RxRst) begin
        if (RxRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (deserializer_en) begin
                    next_state = HUNT;
                end
            end
            HUNT: begin
                if (!deserializer_en) begin
                    next_state = IDLE;
                end else if (match) begin
                    next_state = ACTIVE;
                end else if (timeout_hit) begin
                    next_state = ERROR;
                end
            end
            ACTIVE: begin
                if (!deserializer_en) begin
                    next_state = IDLE;
                end
            end
            ERROR: begin
                if (!deserializer_en) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered PPI outputs for the current state and inputs.
    always_comb begin
        data_d     = 8'h00;
        valid_d    = 1'b0;
        active_d   = 1'b0;
        sync_d     = 1'b0;
        err_sot_d  = 1'b0;
        err_sync_d = 1'b0;
        case (state)
            HUNT: begin
                if (deserializer_en && match) begin
                    sync_d    = 1'b1;
                    active_d  = 1'b1;
                    err_sot_d = match_err;
                end else if (deserializer_en && timeout_hit) begin
                    err_sync_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (deserializer_en) begin
                    active_d = 1'b1;
                    valid_d  = 1'b1;
                    data_d   = bit_reverse(cand[offset]);
                end
            end
            ERROR: begin
                if (deserializer_en) begin
                    err_sync_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge RxByteClkHS or posedge RxRst) begin
        if (RxRst) begin
            RxDataHS     <= 8'h00;
            RxValidHS    <= 1'b0;
            RxActiveHS   <= 1'b0;
            RxSyncHS     <= 1'b0;
            ErrSotHS     <= 1'b0;
            ErrSotSyncHS <= 1'b0;
        end else begin
            RxDataHS     <= data_d;
            RxValidHS    <= valid_d;
            RxActiveHS   <= active_d;
            RxSyncHS     <= sync_d;
            ErrSotHS     <= err_sot_d;
            ErrSotSyncHS <= err_sync_d;
        end
    end

    // Byte history, lock offset and hunt timeout counter.
    always_ff @(posedge RxByteClkHS or posedge RxRst) begin
        if (RxRst) begin
            prev        <= 8'h00;
            offset      <= 3'd0;
            timeout_cnt <= 8'd0;
        end else begin
            prev <= parallel_in;
            case (state)
                IDLE: begin
                    timeout_cnt <= 8'd0;
                end
                HUNT: begin
                    if (match) begin
                        offset <= match_idx;
                    end else begin
                        timeout_cnt <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hs_sync_aligner.sv
// Directed bench for hs_sync_aligner; a second instance without 1-bit
// tolerance runs alongside on the same stimulus.
module tb_hs_sync_aligner;

    logic       clk;
    logic       rst;
    logic [7:0] pin;
    logic       en;

    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       active_a, active_b;
    logic       sync_a, sync_b;
    logic       errsot_a, errsot_b;
    logic       errsync_a, errsync_b;

    int errors = 0;
    int checks = 0;

    hs_sync_aligner dut (
        .RxByteClkHS    (clk),
        .RxRst          (rst),
        .parallel_in    (pin),
        .deserializer_en(en),
        .RxDataHS       (data_a),
        .RxValidHS      (valid_a),
        .RxActiveHS     (active_a),
        .RxSyncHS       (sync_a),
        .ErrSotHS       (errsot_a),
        .ErrSotSyncHS   (errsync_a)
    );

    hs_sync_aligner #(.ALLOW_1BIT_ERR(1'b0)) dut_strict (
        .RxByteClkHS    (clk),
        .RxRst          (rst),
        .parallel_in    (pin),
        .deserializer_en(en),
        .RxDataHS       (data_b),
        .RxValidHS      (valid_b),
        .RxActiveHS     (active_b),
        .RxSyncHS       (sync_b),
        .ErrSotHS       (errsot_b),
        .ErrSotSyncHS   (errsync_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic e, input logic [7:0] b);
        en  = e;
        pin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        en  = 1'b0;
        pin = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Vector order: {sync, active, valid, errsot, errsync, data}
    task automatic checkOutput(input string tag, input bit strict,
                               input logic e_sync, input logic e_active,
                               input logic e_valid, input logic e_errsot,
                               input logic e_errsync, input logic [7:0] e_data);
        logic [12:0] obs;
        logic [12:0] exp;
        if (strict)
            obs = {sync_b, active_b, valid_b, errsot_b, errsync_b, data_b};
        else
            obs = {sync_a, active_a, valid_a, errsot_a, errsync_a, data_a};
        exp = {e_sync, e_active, e_valid, e_errsot, e_errsync, e_data};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        pin = 8'h00;
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_state", 0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("reset_state_strict", 1, 0, 0, 0, 0, 0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] aligned sync");
        applyStimulus(1, 8'h00);
        checkOutput("idle_to_hunt", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'hB8);
        checkOutput("aligned_no_early_lock", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h80);
        checkOutput("aligned_sync", 0, 1, 1, 0, 0, 0, 8'h00);
        checkOutput("aligned_sync_strict", 1, 1, 1, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'hC0);
        checkOutput("aligned_byte0", 0, 0, 1, 1, 0, 0, 8'h01);
        applyStimulus(1, 8'h00);
        checkOutput("aligned_byte1", 0, 0, 1, 1, 0, 0, 8'h03);

        $display("[TB] enable drop and re-burst at offset 5");
        applyStimulus(0, 8'h00);
        checkOutput("drop_inactive", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'h05);
        checkOutput("reburst_hunting", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'hC0);
        checkOutput("offset5_sync", 0, 1, 1, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h38);
        checkOutput("offset5_byte0", 0, 0, 1, 1, 0, 0, 8'hE0);

        $display("[TB] asynchronous reset mid-packet");
        #3 rst = 1'b1;
        #1;
        checkOutput("async_reset", 0, 0, 0, 0, 0, 0, 8'h00);
        checkOutput("async_reset_strict", 1, 0, 0, 0, 0, 0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'h00);
        checkOutput("no_lock_after_reset", 0, 0, 0, 0, 0, 0, 8'h00);

        $display("[TB] sync at offset 3");
        doReset();
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'h17);
        checkOutput("offset3_hunting", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h10);
        checkOutput("offset3_sync", 0, 1, 1, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h00);
        checkOutput("offset3_byte0", 0, 0, 1, 1, 0, 0, 8'h01);
        applyStimulus(1, 8'h00);
        checkOutput("offset3_byte1", 0, 0, 1, 1, 0, 0, 8'h00);

        $display("[TB] single-bit sync error");
        doReset();
        applyStimulus(1, 8'h00);
        applyStimulus(1, 8'hBC);
        applyStimulus(1, 8'h80);
        checkOutput("onebit_sync", 0, 1, 1, 0, 1, 0, 8'h00);
        checkOutput("onebit_strict_nolock", 1, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h00);
        checkOutput("onebit_byte0", 0, 0, 1, 1, 0, 0, 8'h01);
        checkOutput("onebit_strict_still_hunting", 1, 0, 0, 0, 0, 0, 8'h00);

        $display("[TB] sync timeout");
        doReset();
        applyStimulus(1, 8'h00);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1, 8'h00);
        end
        checkOutput("timeout_before_limit", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h00);
        checkOutput("timeout_at_limit", 0, 0, 0, 0, 0, 1, 8'h00);
        checkOutput("timeout_at_limit_strict", 1, 0, 0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h00);
        end
        checkOutput("timeout_sticky", 0, 0, 0, 0, 0, 1, 8'h00);
        applyStimulus(0, 8'h00);
        checkOutput("timeout_cleared", 0, 0, 0, 0, 0, 0, 8'h00);

        $display("[TB] match on the timeout edge");
        doReset();
        applyStimulus(1, 8'h00);
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 8'h00);
        end
        applyStimulus(1, 8'hB8);
        checkOutput("late_no_timeout_yet", 0, 0, 0, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h80);
        checkOutput("match_beats_timeout", 0, 1, 1, 0, 0, 0, 8'h00);
        applyStimulus(1, 8'h00);
        checkOutput("match_beats_timeout_byte0", 0, 0, 1, 1, 0, 0, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
